// File: rtl/instr_encoder_loader.sv
// Field-level instruction encoder that checks requests against a MIPS subset
// and streams legal 32-bit words into instruction memory, one word per two cycles.
`timescale 1ns/1ps
module instr_encoder_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [5:0]    opcode,
  input  logic [5:0]    func,
  input  logic [4:0]    rs,
  input  logic [4:0]    rt,
  input  logic [4:0]    rd,
  input  logic [4:0]    shamt,
  input  logic [15:0]   imm,
  input  logic [25:0]   target,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [AW:0]   word_count,
  output logic [7:0]    illegal_count,
  output logic          full,
  output logic [1:0]    dbg_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready never depends on req_valid, and is low in WRITE, FULL, reset and start.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [AW:0] LAST_COUNT = (AW+1)'(DEPTH - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [AW:0]   r_count;
  logic [7:0]    r_illegal;
  logic [31:0]   r_wdata;
  logic          w_legal;
  logic          w_accept;
  logic          w_last;
  logic [31:0]   w_word;

  always_comb begin
    w_legal = 1'b0;
    if (opcode == 6'b000000) begin
      case (func)
        6'b100110, 6'b000000, 6'b000100, 6'b000010, 6'b000110, 6'b000011,
        6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b011000, 6'b011010,
        6'b100101, 6'b100111, 6'b100100, 6'b101010, 6'b001000: w_legal = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end else begin
      case (opcode)
        6'b001000, 6'b001001, 6'b001100, 6'b001110, 6'b001101, 6'b000100,
        6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b100011, 6'b101011,
        6'b001010, 6'b001111, 6'b000010, 6'b000011: w_legal = 1'b1;
        default: w_legal = 1'b0;
      endcase
    end
  end

  // Fields pass through untouched; the opcode alone selects the format.
  always_comb begin
    w_word = {opcode, rs, rt, imm};
    if (opcode == 6'b000000) begin
      w_word = {opcode, rs, rt, rd, shamt, func};
    end else if (opcode == 6'b000010 || opcode == 6'b000011) begin
      w_word = {opcode, target};
    end
  end

  assign w_last = (r_count == LAST_COUNT);

  // start overrides every state, so a write in flight is dropped before mem_we rises.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_we    = 1'b0;
    w_accept  = 1'b0;
    if (start) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          req_ready = rst_n;
          w_accept  = req_valid && rst_n;
          if (w_accept && w_legal) w_next = S_WRITE;
        end
        S_WRITE: begin
          mem_we = 1'b1;
          w_next = w_last ? S_FULL : S_IDLE;
        end
        S_FULL:  w_next = S_FULL;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // The address stops at DEPTH-1 instead of wrapping once the memory is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_illegal <= '0;
      r_wdata   <= '0;
    end else if (start) begin
      r_addr    <= '0;
      r_count   <= '0;
      r_illegal <= '0;
    end else begin
      if (w_accept) begin
        if (w_legal)                 r_wdata   <= w_word;
        else if (r_illegal != 8'hFF) r_illegal <= r_illegal + 8'd1;
      end
      if (r_state == S_WRITE) begin
        r_count <= r_count + 1'b1;
        if (!w_last) r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign mem_addr      = r_addr;
  assign mem_wdata     = r_wdata;
  assign word_count    = r_count;
  assign illegal_count = r_illegal;
  assign full          = (r_state == S_FULL);
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: vector table, hand-written corner sequences and
// random requests scored against a transaction-level model of the loader.
`timescale 1ns/1ps
module tb_instr_encoder_loader;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [5:0]    opcode = '0;
  logic [5:0]    func = '0;
  logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [15:0]   imm = '0;
  logic [25:0]   target = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic [7:0]    illegal_count;
  logic          full;
  logic [1:0]    dbg_state;

  instr_encoder_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_valid(req_valid), .req_ready(req_ready),
    .opcode(opcode), .func(func), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm),
    .target(target), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .word_count(word_count), .illegal_count(illegal_count), .full(full), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  // ---------------- types, model ----------------
  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [25:0] target;
  } req_t;

  typedef struct {
    req_t        r;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  localparam logic [5:0] LEGAL_RF [17] = '{
    6'b100110, 6'b000000, 6'b000100, 6'b000010, 6'b000110, 6'b000011,
    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b011000, 6'b011010,
    6'b100101, 6'b100111, 6'b100100, 6'b101010, 6'b001000};
  localparam logic [5:0] LEGAL_OP [16] = '{
    6'b001000, 6'b001001, 6'b001100, 6'b001110, 6'b001101, 6'b000100,
    6'b000101, 6'b000110, 6'b000111, 6'b000001, 6'b100011, 6'b101011,
    6'b001010, 6'b001111, 6'b000010, 6'b000011};

  int n_checks = 0;
  int n_errors = 0;
  int m_words  = 0;
  int m_illegal = 0;
  logic [AW+31:0] exp_q[$];

  function automatic req_t mk(logic [5:0] op, logic [5:0] fn, logic [4:0] s, logic [4:0] t,
                              logic [4:0] d, logic [4:0] sh, logic [15:0] im, logic [25:0] tg);
    req_t r;
    r.opcode = op; r.func = fn; r.rs = s; r.rt = t; r.rd = d; r.shamt = sh;
    r.imm = im; r.target = tg;
    return r;
  endfunction

  function automatic bit m_legal(req_t r);
    if (r.opcode == 6'd0) begin
      for (int i = 0; i < 17; i++) if (LEGAL_RF[i] == r.func) return 1'b1;
      return 1'b0;
    end
    for (int i = 0; i < 16; i++) if (LEGAL_OP[i] == r.opcode) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_encode(req_t r);
    if (r.opcode == 6'd0) return {r.opcode, r.rs, r.rt, r.rd, r.shamt, r.func};
    if (r.opcode == 6'd2 || r.opcode == 6'd3) return {r.opcode, r.target};
    return {r.opcode, r.rs, r.rt, r.imm};
  endfunction

  function automatic void model_accept(req_t r);
    logic [AW-1:0] a;
    if (m_legal(r)) begin
      a = m_words[AW-1:0];
      exp_q.push_back({a, m_encode(r)});
      m_words++;
    end else if (m_illegal < 255) begin
      m_illegal++;
    end
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    m_words = 0;
    m_illegal = 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: every write must match the model ----------------
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (rst_n && mem_we) begin
      check("ready_low_in_write", {31'd0, req_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: addr %0d data 0x%08h, required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, e[AW+31:32]});
        check("write_data", mem_wdata, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks (entered and left at posedge+1) ----------------
  task automatic drive_fields(input req_t r);
    opcode = r.opcode; func = r.func; rs = r.rs; rt = r.rt; rd = r.rd;
    shamt = r.shamt; imm = r.imm; target = r.target;
  endtask

  task automatic do_req(input req_t r, input int budget, output bit acc);
    drive_fields(r);
    req_valid = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (acc) begin
      @(posedge clk);
      model_accept(r);
      #1;
    end else begin
      req_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_req();
    req_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    check("word_count", {{(31-AW){1'b0}}, word_count}, m_words);
    check("illegal_count", {24'd0, illegal_count}, m_illegal);
    check("full", {31'd0, full}, {31'd0, m_words == DEPTH});
  endtask

  task automatic pulse_start(input bit with_req);
    start = 1'b1;
    req_valid = with_req;
    @(negedge clk);
    check("start_mem_we", {31'd0, mem_we}, 32'd0);
    check("start_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    req_valid = 1'b0;
    model_clear();
  endtask

  task automatic random_req(output req_t r);
    int sel;
    r = mk(6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), 16'($urandom), 26'($urandom));
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      r.opcode = 6'd0;
      if ($urandom_range(0, 1) == 1) r.func = LEGAL_RF[$urandom_range(0, 16)];
    end else if (sel != 3) begin
      r.opcode = LEGAL_OP[$urandom_range(0, 15)];
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[11];
  bit   acc;
  req_t rq;

  initial begin
    vecs[0]  = '{mk(6'b000000, 6'b100000, 1, 2, 3, 0, 16'hFFFF, 26'h3FFFFFF), 1'b1, 32'h00221820};
    vecs[1]  = '{mk(6'b100011, 6'h3F, 29, 4, 7, 5, 16'hFFFC, 26'h0), 1'b1, 32'h8FA4FFFC};
    vecs[2]  = '{mk(6'b111111, 6'b100000, 1, 2, 3, 0, 16'h0, 26'h0), 1'b0, 32'h0};
    vecs[3]  = '{mk(6'b000000, 6'b000000, 0, 1, 2, 4, 16'h0, 26'h0), 1'b1, 32'h00011100};
    vecs[4]  = '{mk(6'b000011, 6'h3F, 31, 31, 31, 31, 16'h1234, 26'h3FFFFFF), 1'b1, 32'h0FFFFFFF};
    vecs[5]  = '{mk(6'b000000, 6'b000001, 1, 2, 3, 0, 16'h0, 26'h0), 1'b0, 32'h0};
    vecs[6]  = '{mk(6'b000100, 6'h0, 1, 2, 0, 0, 16'h8000, 26'h0), 1'b1, 32'h10228000};
    vecs[7]  = '{mk(6'b010000, 6'h0, 1, 2, 0, 0, 16'h1, 26'h0), 1'b0, 32'h0};
    vecs[8]  = '{mk(6'b000000, 6'b001000, 31, 0, 0, 0, 16'h0, 26'h0), 1'b1, 32'h03E00008};
    vecs[9]  = '{mk(6'b001111, 6'h0, 0, 1, 0, 0, 16'hABCD, 26'h0), 1'b1, 32'h3C01ABCD};
    vecs[10] = '{mk(6'b000001, 6'h0, 3, 0, 0, 0, 16'hFFFF, 26'h0), 1'b1, 32'h0460FFFF};

    // reset values while rst_n is low
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1;
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_counts();
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // vector table
    for (int i = 0; i < 11; i++) begin
      if (m_words == DEPTH) pulse_start(1'b0);
      do_req(vecs[i].r, 20, acc);
      check("vec_accept", {31'd0, acc}, 32'd1);
      finish_req();
      if (vecs[i].legal) check("vec_word", mem_wdata, vecs[i].word);
      check_counts();
    end

    // back-to-back ADDI then J with req_valid held high
    pulse_start(1'b0);
    do_req(mk(6'b001000, 6'h0, 0, 5, 0, 0, 16'h0007, 26'h0), 5, acc);
    check("b2b_first_accept", {31'd0, acc}, 32'd1);
    do_req(mk(6'b000010, 6'h0, 0, 0, 0, 0, 16'h0, 26'h0000100), 2, acc);
    check("b2b_second_accept", {31'd0, acc}, 32'd1);
    finish_req();
    check("b2b_last_word", mem_wdata, 32'h08000100);
    check_counts();

    // LW then an illegal opcode: address unchanged
    pulse_start(1'b0);
    do_req(vecs[1].r, 5, acc);
    finish_req();
    check("lw_word", mem_wdata, 32'h8FA4FFFC);
    do_req(vecs[2].r, 5, acc);
    check("illegal_accept", {31'd0, acc}, 32'd1);
    finish_req();
    check("illegal_addr_hold", {{(32-AW){1'b0}}, mem_addr}, 32'd1);
    check("illegal_wdata_hold", mem_wdata, 32'h8FA4FFFC);
    check_counts();

    // fill to DEPTH, then the next request stalls
    pulse_start(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      do_req(mk(6'b001001, 6'h0, 5'(i), 5'(i + 1), 0, 0, 16'(i * 3), 26'h0), 5, acc);
    end
    finish_req();
    check_counts();
    check("full_req_ready", {31'd0, req_ready}, 32'd0);
    do_req(vecs[0].r, 8, acc);
    check("full_stall", {31'd0, acc}, 32'd0);
    check_counts();
    pulse_start(1'b0);
    check_counts();

    // start during the WRITE cycle of the 2nd word
    do_req(vecs[3].r, 5, acc);
    finish_req();
    do_req(vecs[6].r, 5, acc);
    pulse_start(1'b0);
    check_counts();
    do_req(vecs[9].r, 5, acc);
    finish_req();
    check_counts();

    // start coincident with a request: not accepted
    drive_fields(vecs[0].r);
    pulse_start(1'b1);
    @(posedge clk);
    #1;
    check_counts();

    // illegal counter saturation
    for (int i = 0; i < 260; i++) do_req(vecs[7].r, 4, acc);
    finish_req();
    check_counts();

    // random requests
    pulse_start(1'b0);
    for (int n = 0; n < 300; n++) begin
      if (m_words == DEPTH) begin
        if ($urandom_range(0, 1) == 1) begin
          random_req(rq);
          do_req(rq, 3, acc);
          check("rand_full_stall", {31'd0, acc}, 32'd0);
        end
        pulse_start(1'($urandom_range(0, 1)));
      end else if ($urandom_range(0, 19) == 0) begin
        random_req(rq);
        drive_fields(rq);
        pulse_start(1'($urandom_range(0, 1)));
      end
      random_req(rq);
      do_req(rq, 6, acc);
      check("rand_accept", {31'd0, acc}, 32'd1);
      if ($urandom_range(0, 1) == 1) begin
        finish_req();
        check_counts();
      end
    end
    finish_req();
    finish_req();
    check_counts();

    // asynchronous reset in the middle of a WRITE cycle
    pulse_start(1'b0);
    do_req(vecs[4].r, 5, acc);
    req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_mem_we", {31'd0, mem_we}, 32'd0);
    check("arst_mem_addr", {{(32-AW){1'b0}}, mem_addr}, 32'd0);
    check("arst_mem_wdata", mem_wdata, 32'd0);
    check("arst_req_ready", {31'd0, req_ready}, 32'd0);
    model_clear();
    check_counts();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_req(vecs[8].r, 5, acc);
    finish_req();
    check_counts();
    check("post_reset_word", mem_wdata, 32'h03E00008);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
